// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the operand entry sequencer and its bench.
//   OPERAND_W     - width of each calculator operand (switch bank width)
//   entry_state_t - field currently being entered; the encoding is also the
//                   value shown on the phase status LEDs
package calc_pkg;

   localparam int OPERAND_W = 4;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      ENTER_S = 2'd2,
      SHOW    = 2'd3
   } entry_state_t;

endpackage

// File: rtl/calc_operand_entry_if.sv
// calc_operand_entry_if: user-facing signals of the operand entry sequencer.
//   sw        raw slide switches (asynchronous to clk)
//   btn       raw pushbutton, active-high, bouncy (asynchronous to clk)
//   a, b      captured operands, to calculator a3..a0 / b3..b0
//   s         captured select, 0 = add, 1 = subtract
//   valid     level flag: high while a, b and s all belong to the current
//             entry round (set when s is captured, cleared when the
//             sequencer returns to operand A); there is no ready, the
//             calculator consumes the values combinationally
//   phase     field being entered: 0 = A, 1 = B, 2 = S, 3 = SHOW
//   btn_level debounced button level, for observation
// master is the sequencer side, slave is the switch/LED/calculator side.
interface calc_operand_entry_if;
   import calc_pkg::*;

   logic [OPERAND_W-1:0] sw;
   logic                 btn;
   logic [OPERAND_W-1:0] a;
   logic [OPERAND_W-1:0] b;
   logic                 s;
   logic                 valid;
   logic [1:0]           phase;
   logic                 btn_level;

   modport master (
      input  sw, btn,
      output a, b, s, valid, phase, btn_level
   );

   modport slave (
      output sw, btn,
      input  a, b, s, valid, phase, btn_level
   );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw pushbutton, debounces it and emits one
// registered pulse per accepted press.
//   clk, rst_n  clock, asynchronous active-low reset
//   btn_raw     raw button input, asynchronous to clk
//   level       debounced button level
//   press       one-cycle pulse, the cycle after level rises
// A level change is accepted only after btn_sync has differed from the
// current level for DEBOUNCE_CYCLES consecutive cycles (legal: >= 2).
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             stable_dly_q, stable_dly_d;
   logic             press_q, press_d;
   logic             btn_sync;

   assign btn_sync = sync_q[1];

   always_comb begin
      sync_d       = {sync_q[0], btn_raw};
      stable_d     = stable_q;
      cnt_d        = '0;
      // Count consecutive disagreeing cycles; any agreeing cycle restarts
      // the count, which is what rejects short glitches.
      if (btn_sync != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      stable_dly_d = stable_q;
      // Rising edge of the debounced level only; release gives no pulse.
      press_d      = stable_q & ~stable_dly_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '0;
         cnt_q        <= '0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         press_q      <= press_d;
      end
   end

   assign level = stable_q;
   assign press = press_q;

endmodule

// File: rtl/calc_operand_entry.sv
// calc_operand_entry: lets the user enter operand A, operand B and the
// add/subtract select one at a time from a 4-bit switch bank, advancing one
// field per debounced button press.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         calc_operand_entry_if.master: sw/btn in; a, b, s, valid,
//               phase, btn_level out
// Outputs are all registers; phase is the state register itself.
module calc_operand_entry
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   calc_operand_entry_if.master  bus
);

   logic [OPERAND_W-1:0] sw_meta_q, sw_meta_d;
   logic [OPERAND_W-1:0] sw_sync_q, sw_sync_d;
   entry_state_t         state_q, state_d;
   logic [OPERAND_W-1:0] a_q, a_d;
   logic [OPERAND_W-1:0] b_q, b_d;
   logic                 s_q, s_d;
   logic                 valid_q, valid_d;
   logic                 press;
   logic                 btn_level;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (bus.btn),
      .level   (btn_level),
      .press   (press)
   );

   always_comb begin
      sw_meta_d = bus.sw;
      sw_sync_d = sw_meta_q;
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      s_d       = s_q;
      valid_d   = valid_q;
      if (press) begin
         case (state_q)
            ENTER_A: begin
               a_d     = sw_sync_q;
               state_d = ENTER_B;
            end
            ENTER_B: begin
               b_d     = sw_sync_q;
               state_d = ENTER_S;
            end
            ENTER_S: begin
               // Only switch 0 selects add/subtract.
               s_d     = sw_sync_q[0];
               valid_d = 1'b1;
               state_d = SHOW;
            end
            SHOW: begin
               // Old operands stay on the outputs until overwritten.
               valid_d = 1'b0;
               state_d = ENTER_A;
            end
            default: state_d = ENTER_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         state_q   <= ENTER_A;
         a_q       <= '0;
         b_q       <= '0;
         s_q       <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         s_q       <= s_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.s         = s_q;
   assign bus.valid     = valid_q;
   assign bus.phase     = state_q;
   assign bus.btn_level = btn_level;

endmodule

// File: tb/tb_calc_operand_entry.sv
module tb_calc_operand_entry;
  import calc_pkg::*;

  localparam int DC  = 16;
  // Inputs change on a falling edge; the next rising edge is the first
  // sampling edge k, and fields update at edge k + DC + 3.
  localparam int LAT = DC + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  calc_operand_entry_if ifc ();

  calc_operand_entry #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Output word: {phase, a, b, s, valid}
  logic [11:0] exp_q[$];
  int          exp_t_q[$];
  string       chk_name_q[$];
  logic [11:0] chk_act_q[$];
  logic [11:0] chk_exp_q[$];

  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [11:0] prev_obs = '0;
  logic [11:0] mon_cur;
  logic [11:0] mon_e;
  int          mon_t;
  string       c_name;
  logic [11:0] c_act;
  logic [11:0] c_exp;

  function automatic logic [11:0] pk(input logic [1:0] ph, input logic [3:0] av,
                                     input logic [3:0] bv, input logic sv, input logic vv);
    return {ph, av, bv, sv, vv};
  endfunction

  function automatic logic [11:0] obs();
    return {ifc.phase, ifc.a, ifc.b, ifc.s, ifc.valid};
  endfunction

  always @(negedge clk) begin
    while (chk_name_q.size() != 0) begin
      c_name = chk_name_q.pop_front();
      c_act  = chk_act_q.pop_front();
      c_exp  = chk_exp_q.pop_front();
      checks++;
      if (c_act !== c_exp) begin
        errors++;
        $display("FAIL %s: got %h, required %h", c_name, c_act, c_exp);
      end
    end
    if (mon_en) begin
      mon_cur = obs();
      if (mon_cur !== prev_obs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h, required unchanged %h (cycle %0d)",
                   mon_cur, prev_obs, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = exp_t_q.pop_front();
          if (mon_cur !== mon_e) begin
            errors++;
            $display("FAIL out_value: got %h, required %h (cycle %0d)", mon_cur, mon_e, cyc);
          end
          if (mon_t >= 0) begin
            checks++;
            if (cyc != mon_t) begin
              errors++;
              $display("FAIL update_edge: got edge %0d, required edge %0d", cyc, mon_t);
            end
          end
        end
        prev_obs = mon_cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample_check(input string name, input logic [11:0] exp);
    chk_name_q.push_back(name);
    chk_act_q.push_back(obs());
    chk_exp_q.push_back(exp);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_name_q.push_back({name, "_pending"});
    chk_act_q.push_back(12'(exp_q.size()));
    chk_exp_q.push_back(12'h000);
    exp_q.delete();
    exp_t_q.delete();
  endtask

  // Set switches, optionally bounce (5 high / 5 low), then hold and release.
  task automatic press(input logic [3:0] swv, input int hold, input int bounces,
                       input logic [11:0] exp, input string name);
    @(negedge clk);
    ifc.sw = swv;
    repeat (4) @(negedge clk);
    for (int i = 0; i < bounces; i++) begin
      ifc.btn = 1'b1;
      repeat (5) @(negedge clk);
      ifc.btn = 1'b0;
      repeat (5) @(negedge clk);
    end
    ifc.btn = 1'b1;
    exp_q.push_back(exp);
    exp_t_q.push_back(cyc + LAT);
    repeat (hold) @(negedge clk);
    ifc.btn = 1'b0;
    repeat (DC + 10) @(negedge clk);
    drain(name);
    sample_check({name, "_hold"}, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ifc.sw  = 4'h0;
    ifc.btn = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    sample_check("reset_state", 12'h000);
    rst_n    = 1'b1;
    prev_obs = 12'h000;
    mon_en   = 1'b1;

    // Clean sequence
    press(4'b0011, 30, 0, pk(2'd1, 4'h3, 4'h0, 1'b0, 1'b0), "clean_a");
    press(4'b0101, 30, 0, pk(2'd2, 4'h3, 4'h5, 1'b0, 1'b0), "clean_b");
    press(4'b0001, 30, 0, pk(2'd3, 4'h3, 4'h5, 1'b1, 1'b1), "clean_s");
    // Wrap-around from SHOW keeps a/b/s
    press(4'hA,    30, 0, pk(2'd0, 4'h3, 4'h5, 1'b1, 1'b0), "wrap");
    // Bounce rejection, captures sw=F into a only
    press(4'hF,    40, 6, pk(2'd1, 4'hF, 4'h5, 1'b1, 1'b0), "bounce_a");
    // Long hold: one advance, release no advance
    press(4'hE,  1000, 0, pk(2'd2, 4'hF, 4'hE, 1'b1, 1'b0), "long_hold_b");
    // Select width
    press(4'b1110, 30, 0, pk(2'd3, 4'hF, 4'hE, 1'b0, 1'b1), "sel_1110");
    press(4'h0,    30, 0, pk(2'd0, 4'hF, 4'hE, 1'b0, 1'b0), "wrap2");
    press(4'h1,    30, 0, pk(2'd1, 4'h1, 4'hE, 1'b0, 1'b0), "a2");
    press(4'h2,    30, 0, pk(2'd2, 4'h1, 4'h2, 1'b0, 1'b0), "b2");
    press(4'b1111, 30, 0, pk(2'd3, 4'h1, 4'h2, 1'b1, 1'b1), "sel_1111");
    press(4'h0,    30, 0, pk(2'd0, 4'h1, 4'h2, 1'b1, 1'b0), "wrap3");
    press(4'h4,    30, 0, pk(2'd1, 4'h4, 4'h2, 1'b1, 1'b0), "a3");
    press(4'h9,    30, 0, pk(2'd2, 4'h4, 4'h9, 1'b1, 1'b0), "b3");

    // Reset mid-operation: phase 2, debounce counter mid-count
    @(negedge clk);
    ifc.sw  = 4'h3;
    ifc.btn = 1'b1;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2;
    exp_q.push_back(12'h000);
    exp_t_q.push_back(-1);
    rst_n = 1'b0;
    #1;
    sample_check("reset_async", 12'h000);
    ifc.btn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain("reset_async_seen");
    press(4'h7,    30, 0, pk(2'd1, 4'h7, 4'h0, 1'b0, 1'b0), "after_reset_a");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
